pipe_stage_regs: RTL and testbench

//  Parametrised elastic pipeline register chain: STAGES back-to-back registers of WIDTH bits,

---
 rtl/pipe_stage_regs_if.sv | 27 ++
 rtl/pipe_stage_regs.sv | 105 ++++++++++
 tb/tb_pipe_stage_regs.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_regs_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_regs_if : valid/ready/data handshake bundle for the register chain
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pipe_stage_regs_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// pipe_stage_regs : elastic valid/ready register chain with flush and occupancy
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_stage_regs #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               DATA_RST  = 1'b1,
  localparam int unsigned     OCC_W     = $clog2(STAGES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  pipe_stage_regs_if.slave  up_if,
  pipe_stage_regs_if.master dn_if,
  output logic [OCC_W-1:0]  occupancy_o
);

  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0]            valid_d;
  logic [STAGES-1:0]            adv;
  logic [STAGES-1:0]            load;
  logic [STAGES-1:0][WIDTH-1:0] data_q;
  logic [STAGES-1:0][WIDTH-1:0] data_d;
  logic                         in_ready;

  // Readiness ripples from the output back to stage 0 in a single pass,
  // so an empty stage anywhere lets everything upstream of it move.
  always_comb begin : p_flow
    logic chain_rdy;
    chain_rdy = dn_if.ready;
    adv       = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      adv[i]    = valid_q[i] & chain_rdy;
      chain_rdy = ~valid_q[i] | adv[i];
    end
    in_ready = chain_rdy;
  end

  always_comb begin : p_next
    load    = '0;
    valid_d = valid_q;
    data_d  = data_q;

    load[0] = up_if.valid & in_ready & ~flush_i;
    for (int i = 1; i < int'(STAGES); i++) begin
      load[i] = adv[i-1] & ~flush_i;
    end

    for (int i = 0; i < int'(STAGES); i++) begin
      valid_d[i] = load[i] | (valid_q[i] & ~adv[i]);
    end
    if (flush_i) begin
      valid_d = '0;
    end

    if (load[0]) begin
      data_d[0] = up_if.data;
    end
    for (int i = 1; i < int'(STAGES); i++) begin
      if (load[i]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  if (DATA_RST) begin : g_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_q <= {STAGES{RESET_VAL}};
      end else begin
        data_q <= data_d;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      data_q <= data_d;
    end
  end

  always_comb begin : p_occ
    occupancy_o = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      occupancy_o = occupancy_o + OCC_W'(valid_q[i]);
    end
  end

  assign up_if.ready = in_ready;
  assign dn_if.valid = valid_q[STAGES-1];
  assign dn_if.data  = data_q[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_regs : three chains (3, 1 and 16 stages) against a beat-position model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_stage_regs;

  localparam int NK = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [NK];
  logic        ordy [NK];
  logic        fl   [NK];
  logic [31:0] idat [NK];
  logic        ir   [NK];
  logic        ov   [NK];
  logic [31:0] od   [NK];
  int          occ  [NK];
  logic [1:0]  occ0;
  logic        occ1;
  logic [4:0]  occ2;

  always #5 clk = ~clk;

  pipe_stage_regs_if #(.WIDTH(32)) up0 ();
  pipe_stage_regs_if #(.WIDTH(32)) dn0 ();
  pipe_stage_regs_if #(.WIDTH(32)) up1 ();
  pipe_stage_regs_if #(.WIDTH(32)) dn1 ();
  pipe_stage_regs_if #(.WIDTH(32)) up2 ();
  pipe_stage_regs_if #(.WIDTH(32)) dn2 ();

  pipe_stage_regs #(.WIDTH(32), .STAGES(3), .RESET_VAL(32'hDEAD_BEEF), .DATA_RST(1'b1)) u_s3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[0]), .up_if(up0), .dn_if(dn0), .occupancy_o(occ0));
  pipe_stage_regs #(.WIDTH(32), .STAGES(1), .RESET_VAL(32'h0), .DATA_RST(1'b1)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[1]), .up_if(up1), .dn_if(dn1), .occupancy_o(occ1));
  pipe_stage_regs #(.WIDTH(32), .STAGES(16), .RESET_VAL(32'h0), .DATA_RST(1'b0)) u_s16 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[2]), .up_if(up2), .dn_if(dn2), .occupancy_o(occ2));

  assign up0.valid = iv[0];  assign up0.data = idat[0];  assign dn0.ready = ordy[0];
  assign up1.valid = iv[1];  assign up1.data = idat[1];  assign dn1.ready = ordy[1];
  assign up2.valid = iv[2];  assign up2.data = idat[2];  assign dn2.ready = ordy[2];
  assign ir[0] = up0.ready;  assign ov[0] = dn0.valid;   assign od[0] = dn0.data;
  assign ir[1] = up1.ready;  assign ov[1] = dn1.valid;   assign od[1] = dn1.data;
  assign ir[2] = up2.ready;  assign ov[2] = dn2.valid;   assign od[2] = dn2.data;
  assign occ[0] = int'(occ0);
  assign occ[1] = int'(occ1);
  assign occ[2] = int'(occ2);

  // Model: each chain is an ordered list of beats, each with its stage position.
  logic [31:0] mq_d [NK][$];
  int          mq_p [NK][$];
  bit          lastacc [NK];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic int depth(input int k);
    case (k)
      0:       return 3;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic bit m_ovalid(input int k);
    return (mq_p[k].size() > 0) && (mq_p[k][0] == depth(k) - 1);
  endfunction

  function automatic bit m_iready(input int k);
    return (mq_d[k].size() < depth(k)) || (ordy[k] == 1'b1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      mq_d[k].delete();
      mq_p[k].delete();
      lastacc[k] = 1'b0;
    end
  endtask

  // A beat moves up one position unless the beat ahead of it (after its own move) blocks it.
  task automatic model_step();
    bit acc;
    int lim;
    int np;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < NK; k++) begin
        acc = (iv[k] == 1'b1) && m_iready(k) && (fl[k] == 1'b0);
        if (m_ovalid(k) && ordy[k] == 1'b1) begin
          void'(mq_d[k].pop_front());
          void'(mq_p[k].pop_front());
        end
        if (fl[k] == 1'b1) begin
          mq_d[k].delete();
          mq_p[k].delete();
        end else begin
          lim = depth(k);
          for (int j = 0; j < mq_p[k].size(); j++) begin
            np = mq_p[k][j] + 1;
            if (np > lim - 1) np = lim - 1;
            mq_p[k][j] = np;
            lim = np;
          end
          if (acc) begin
            mq_d[k].push_back(idat[k]);
            mq_p[k].push_back(0);
          end
        end
        lastacc[k] = acc;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NK; k++) begin
      cmp($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(m_ovalid(k)));
      cmp($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(m_iready(k)));
      cmp($sformatf("occupancy[%0d]", k), 32'(occ[k]), 32'(mq_d[k].size()));
      if (m_ovalid(k)) begin
        cmp($sformatf("out_data[%0d]", k), od[k], mq_d[k][0]);
      end
    end
  endtask

  task automatic half_neg();
    @(negedge clk);
    check_all();
  endtask

  task automatic half_pos();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NK; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; fl[k] = 1'b0; idat[k] = 32'h0;
    end
  endtask

  task automatic rand_drive(input int pr);
    for (int k = 0; k < NK; k++) begin
      if (!(iv[k] == 1'b1 && !lastacc[k])) begin
        iv[k]   = ($urandom_range(0, 9) < 7);
        idat[k] = $urandom;
      end
      ordy[k] = ($urandom_range(0, 99) < pr);
      fl[k]   = ($urandom_range(0, 63) == 0);
    end
  endtask

  initial begin
    int nb;
    logic [31:0] t4d [5];
    logic [31:0] t5d [4];
    t4d = '{32'hA0, 32'h0, 32'hB0, 32'h0, 32'hC0};
    t5d = '{32'h51, 32'h52, 32'h53, 32'h5F};

    rst_n = 1'b1;
    idle_all();
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_ov", 32'(ov[0]), 32'h0);
    cmp("rst_od", od[0], 32'hDEAD_BEEF);
    cmp("rst_occ", 32'(occ[0]), 32'h0);
    half_neg(); half_pos();
    half_neg(); half_pos();
    rst_n = 1'b1;
    half_neg(); half_pos();

    // Stream of 10 back-to-back beats
    ordy[0] = 1'b1;
    for (int t = 0; t < 14; t++) begin
      iv[0] = (t < 10); idat[0] = 32'(t + 1);
      half_neg();
      cmp("stream_ov", 32'(ov[0]), 32'(t >= 3 && t <= 12));
      if (t >= 3 && t <= 12) cmp("stream_od", od[0], 32'(t - 2));
      half_pos();
    end

    // Back-pressure for 5 cycles while sending 11..18
    nb = 11; iv[0] = 1'b1; idat[0] = 32'(nb);
    for (int t = 0; t < 14; t++) begin
      ordy[0] = (t >= 5);
      iv[0]   = (nb <= 18);
      half_neg();
      if (t < 5) begin
        cmp("bp_occ", 32'(occ[0]), 32'((t < 3) ? t : 3));
        cmp("bp_ir", 32'(ir[0]), 32'(t < 3));
      end
      half_pos();
      if (lastacc[0]) begin nb++; idat[0] = 32'(nb); end
    end
    iv[0] = 1'b0;

    // Bubble collapse A,_,B,_,C then drain
    for (int t = 0; t < 10; t++) begin
      ordy[0] = (t >= 6);
      iv[0]   = (t < 5) && (t % 2 == 0);
      idat[0] = (t < 5) ? t4d[t] : 32'h0;
      half_neg();
      if (t < 5) cmp("bub_ir", 32'(ir[0]), 32'h1);
      if (t == 5) begin
        cmp("bub_ir_full", 32'(ir[0]), 32'h0);
        cmp("bub_occ", 32'(occ[0]), 32'h3);
      end
      if (t >= 6 && t <= 8) begin
        cmp("bub_ov", 32'(ov[0]), 32'h1);
        cmp("bub_od", od[0], (t == 6) ? 32'hA0 : (t == 7) ? 32'hB0 : 32'hC0);
      end
      half_pos();
    end

    // Flush a full chain with an input handshake pending
    for (int t = 0; t < 8; t++) begin
      ordy[0] = (t >= 5);
      iv[0]   = (t < 4);
      idat[0] = (t < 4) ? t5d[t] : 32'h0;
      fl[0]   = (t == 3);
      half_neg();
      if (t == 3) cmp("fl_full", 32'(occ[0]), 32'h3);
      if (t == 4) cmp("fl_occ", 32'(occ[0]), 32'h0);
      if (t >= 4) cmp("fl_ov", 32'(ov[0]), 32'h0);
      half_pos();
    end
    fl[0] = 1'b0;

    // Asynchronous reset while the chain is full and presenting data
    for (int t = 0; t < 3; t++) begin
      ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 32'h71 + 32'(t);
      half_neg(); half_pos();
    end
    cmp("pre_rst_ov", 32'(ov[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    cmp("mid_rst_ov", 32'(ov[0]), 32'h0);
    cmp("mid_rst_od", od[0], 32'hDEAD_BEEF);
    cmp("mid_rst_occ", 32'(occ[0]), 32'h0);
    model_reset();
    idle_all();
    half_neg(); half_pos();
    rst_n = 1'b1;

    // Random traffic on all three chains
    for (int t = 0; t < 6000; t++) begin
      half_neg();
      half_pos();
      rand_drive((t < 2000) ? 60 : (t < 4000) ? 25 : 90);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
